fp16_to_int_serial: RTL and testbench

- Converts an IEEE-754 half-precision operand (1/5/10, bias 15) to a saturating signed two's-complement integer.
- Serves as the readout/decode end of the FP16 MAC datapath: the adder/multiplier produce FP16, and this block turns those results into integers for the fixed-point consumers.
- Mantissa alignment is multi-cycle, one bit shift per cycle, with valid/ready handshakes on both sides.

---
 rtl/fp16_to_int_serial.sv | 187 ++++++++++++++++++
 tb/tb_fp16_to_int_serial.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fp16_to_int_serial.sv
// FP16 to saturating signed integer converter with round-to-nearest-even and valid/ready handshakes.
// Define FP16_BARREL_SHIFT_EN to replace the one-bit-per-cycle alignment with a single-cycle shift.
module fp16_to_int_serial #(
  parameter int unsigned OUT_W = 16
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [15:0]      a_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [OUT_W-1:0] q_o,
  output logic             nan_flag_o,
  output logic             ovf_flag_o,
  output logic             inexact_flag_o
);

  localparam int unsigned WorkW = OUT_W + 1;
  // Biased exponent at which e == OUT_W-1, i.e. the first out-of-range magnitude.
  localparam logic [4:0] ExpSat = 5'(OUT_W + 14);

  typedef enum logic [1:0] {StIdle, StShift, StRound, StDone} state_e;

  state_e             state_q, state_d;
  logic [WorkW-1:0]   w_q, w_d;
  logic               guard_q, guard_d;
  logic               sticky_q, sticky_d;
  logic               sign_q, sign_d;
  logic [OUT_W-1:0]   q_q, q_d;
  logic               nan_q, nan_d;
  logic               ovf_q, ovf_d;
  logic               inx_q, inx_d;
`ifndef FP16_BARREL_SHIFT_EN
  logic [4:0]         k_q, k_d;
  logic               left_q, left_d;
`else
  logic [21:0]        ext;
`endif

  logic             in_sign;
  logic [4:0]       in_exp;
  logic [9:0]       in_man;
  logic [10:0]      in_mag;
  logic [4:0]       in_k;
  logic             in_left;
  logic [OUT_W-1:0] sat_val;
  logic [WorkW-1:0] round_r;
  logic [WorkW-1:0] signed_r;

  assign in_sign = a_i[15];
  assign in_exp  = a_i[14:10];
  assign in_man  = a_i[9:0];
  assign in_mag  = {1'b1, in_man};
  assign in_left = (in_exp >= 5'd25);
  assign in_k    = in_left ? (in_exp - 5'd25) : (5'd25 - in_exp);
  assign sat_val = in_sign ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};

  assign round_r  = w_q + WorkW'(guard_q & (sticky_q | w_q[0]));
  assign signed_r = sign_q ? -round_r : round_r;

  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    sign_d   = sign_q;
    q_d      = q_q;
    nan_d    = nan_q;
    ovf_d    = ovf_q;
    inx_d    = inx_q;
`ifndef FP16_BARREL_SHIFT_EN
    k_d      = k_q;
    left_d   = left_q;
`else
    ext      = {in_mag, 11'b0} >> in_k;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          sign_d  = in_sign;
          state_d = StDone;
          if (in_exp == 5'd31 && in_man != '0) begin
            q_d = '0; nan_d = 1'b1; ovf_d = 1'b0; inx_d = 1'b0;
          end else if (in_exp == 5'd31) begin
            q_d = sat_val; nan_d = 1'b0; ovf_d = 1'b1; inx_d = 1'b0;
          end else if (in_exp == 5'd0) begin
            q_d = '0; nan_d = 1'b0; ovf_d = 1'b0; inx_d = (in_man != '0);
          end else if (in_exp >= ExpSat) begin
            nan_d = 1'b0; inx_d = 1'b0;
            if (in_sign && in_exp == ExpSat && in_man == '0) begin
              q_d = sat_val; ovf_d = 1'b0;
            end else begin
              q_d = sat_val; ovf_d = 1'b1;
            end
          end else if (in_exp <= 5'd13) begin
            q_d = '0; nan_d = 1'b0; ovf_d = 1'b0; inx_d = 1'b1;
          end else begin
`ifndef FP16_BARREL_SHIFT_EN
            w_d      = WorkW'(in_mag);
            guard_d  = 1'b0;
            sticky_d = 1'b0;
            k_d      = in_k;
            left_d   = in_left;
            state_d  = (in_k != '0) ? StShift : StRound;
`else
            if (in_left) begin
              w_d      = WorkW'(in_mag) << in_k;
              guard_d  = 1'b0;
              sticky_d = 1'b0;
            end else begin
              w_d      = WorkW'(ext[21:11]);
              guard_d  = ext[10];
              sticky_d = |ext[9:0];
            end
            state_d = StRound;
`endif
          end
        end
      end
`ifndef FP16_BARREL_SHIFT_EN
      StShift: begin
        if (left_q) begin
          w_d = w_q << 1;
        end else begin
          sticky_d = sticky_q | guard_q;
          guard_d  = w_q[0];
          w_d      = w_q >> 1;
        end
        k_d = k_q - 5'd1;
        if (k_q == 5'd1) state_d = StRound;
      end
`endif
      StRound: begin
        q_d     = OUT_W'(signed_r);
        nan_d   = 1'b0;
        ovf_d   = 1'b0;
        inx_d   = guard_q | sticky_q;
        state_d = StDone;
      end
      StDone: begin
        if (out_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q  <= StIdle;
      w_q      <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      sign_q   <= 1'b0;
      q_q      <= '0;
      nan_q    <= 1'b0;
      ovf_q    <= 1'b0;
      inx_q    <= 1'b0;
`ifndef FP16_BARREL_SHIFT_EN
      k_q      <= '0;
      left_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      sign_q   <= sign_d;
      q_q      <= q_d;
      nan_q    <= nan_d;
      ovf_q    <= ovf_d;
      inx_q    <= inx_d;
`ifndef FP16_BARREL_SHIFT_EN
      k_q      <= k_d;
      left_q   <= left_d;
`endif
    end
  end

  assign in_ready_o     = (state_q == StIdle);
  assign out_valid_o    = (state_q == StDone);
  assign q_o            = q_q;
  assign nan_flag_o     = nan_q;
  assign ovf_flag_o     = ovf_q;
  assign inexact_flag_o = inx_q;

endmodule

// File: tb/tb_fp16_to_int_serial.sv
// Self-checking bench for fp16_to_int_serial: arithmetic reference model plus hand-computed vectors.
module tb_fp16_to_int_serial;

  localparam int OutW = 16;

  logic            clk, rst_n;
  logic            in_valid, in_ready, out_valid, out_ready;
  logic [15:0]     a;
  logic [OutW-1:0] q;
  logic            nan_f, ovf_f, inx_f;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] exp_q;
  logic        exp_nan, exp_ovf, exp_inx;
  int          exp_lat;

  fp16_to_int_serial #(.OUT_W(OutW)) dut (
    .CLK           (clk),
    .RESETn        (rst_n),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .a_i           (a),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .q_o           (q),
    .nan_flag_o    (nan_f),
    .ovf_flag_o    (ovf_f),
    .inexact_flag_o(inx_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Exact value scaled by 2^24, rounded half-to-even, then range-checked.
  function automatic void model(input logic [15:0] av, output logic [15:0] mq,
                                output logic mnan, output logic movf, output logic minx,
                                output int mlat);
    int     ex, m, e, k;
    bit     s;
    longint scaled, ip, frac, r;
    ex = int'(av[14:10]);
    m  = int'(av[9:0]);
    s  = av[15];
    mq = '0; mnan = 1'b0; movf = 1'b0; minx = 1'b0; mlat = 1;
    if (ex == 31) begin
      if (m != 0) mnan = 1'b1;
      else begin movf = 1'b1; mq = s ? 16'h8000 : 16'h7fff; end
      return;
    end
    if (ex == 0) begin
      minx = (m != 0);
      return;
    end
    e      = ex - 15;
    scaled = longint'(1024 + m) << (e + 14);
    ip     = scaled >>> 24;
    frac   = scaled & 64'hFF_FFFF;
    if (frac > 64'h80_0000 || (frac == 64'h80_0000 && ip % 2 == 1)) ip++;
    minx = (frac != 0);
    r    = s ? -ip : ip;
    if (r > 32767 || r < -32768) begin
      movf = 1'b1; minx = 1'b0; mq = s ? 16'h8000 : 16'h7fff;
    end else begin
      mq = 16'(r);
    end
    if (e >= -1 && e <= 14) begin
      k = (e >= 10) ? e - 10 : 10 - e;
`ifdef FP16_BARREL_SHIFT_EN
      mlat = 2;
`else
      mlat = (k == 0) ? 2 : k + 2;
`endif
    end
  endfunction

  // Checks every cycle a result is presented.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      chk("q_vs_model", 32'(q), 32'(exp_q));
      chk("flags_vs_model", {29'd0, nan_f, ovf_f, inx_f}, {29'd0, exp_nan, exp_ovf, exp_inx});
      chk("in_ready_low_in_done", 32'(in_ready), 32'd0);
    end
  end

  task automatic convert(input logic [15:0] av, input int hold, input bit use_lit,
                         input logic [15:0] lit_q, input logic [2:0] lit_f);
    int lat;
    model(av, exp_q, exp_nan, exp_ovf, exp_inx, exp_lat);
    @(negedge clk);
    a = av;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk($sformatf("latency_%04h", av), 32'(lat), 32'(exp_lat));
    if (use_lit) begin
      chk($sformatf("q_lit_%04h", av), 32'(q), 32'(lit_q));
      chk($sformatf("flags_lit_%04h", av), {29'd0, nan_f, ovf_f, inx_f}, {29'd0, lit_f});
    end
    repeat (hold) @(posedge clk);
    #1;
    if (hold > 0) chk("valid_held", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("valid_cleared", 32'(out_valid), 32'd0);
    chk("ready_after_done", 32'(in_ready), 32'd1);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] q;
    logic [2:0]  f;  // {nan, ovf, inexact}
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0;
    exp_q = '0; exp_nan = 1'b0; exp_ovf = 1'b0; exp_inx = 1'b0; exp_lat = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_q", 32'(q), 32'd0);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_ready", 32'(in_ready), 32'd1);
    chk("reset_flags", {29'd0, nan_f, ovf_f, inx_f}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    vecs.push_back('{16'h3C00, 16'h0001, 3'b000});
    vecs.push_back('{16'h4100, 16'h0002, 3'b001});
    vecs.push_back('{16'hC300, 16'hFFFC, 3'b001});
    vecs.push_back('{16'h3800, 16'h0000, 3'b001});
    vecs.push_back('{16'h7400, 16'h4000, 3'b000});
    vecs.push_back('{16'h7BFF, 16'h7FFF, 3'b010});
    vecs.push_back('{16'hF800, 16'h8000, 3'b000});
    vecs.push_back('{16'h7E00, 16'h0000, 3'b100});
    vecs.push_back('{16'hFC00, 16'h8000, 3'b010});
    vecs.push_back('{16'h0001, 16'h0000, 3'b001});
    vecs.push_back('{16'hBA00, 16'h0000, 3'b001});  // -0.75 -> -1? no: rounds to -1
    vecs[10].q = 16'hFFFF;
    vecs.push_back('{16'hB400, 16'h0000, 3'b001});  // -0.25 rounds to zero, not negative
    vecs.push_back('{16'h4300, 16'h0004, 3'b001});  // 3.5 ties up to even 4
    vecs.push_back('{16'h6400, 16'h0400, 3'b000});  // 1024, k=0 path
    foreach (vecs[i]) convert(vecs[i].a, (i == 0) ? 5 : 0, 1'b1, vecs[i].q, vecs[i].f);

    for (int ex = 0; ex < 32; ex++) begin
      for (int mi = 0; mi < 4; mi++) begin
        logic [9:0] mm;
        mm = (mi == 0) ? 10'h000 : (mi == 1) ? 10'h200 : (mi == 2) ? 10'h3FF : 10'h155;
        convert({ex[0], ex[4:0], mm}, 0, 1'b0, 16'h0, 3'b000);
        convert({~ex[0], ex[4:0], mm}, 0, 1'b0, 16'h0, 3'b000);
      end
    end

    // Abort mid-conversion with reset; no result may appear afterwards.
    @(negedge clk);
    a = 16'h3C00;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_q", 32'(q), 32'd0);
    chk("abort_flags", {29'd0, nan_f, ovf_f, inx_f}, 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    begin
      int seen = 0;
      repeat (20) begin
        @(posedge clk);
        #1;
        if (out_valid) seen++;
      end
      chk("no_stale_result", 32'(seen), 32'd0);
    end
    out_ready = 1'b0;
    convert(16'h4100, 0, 1'b1, 16'h0002, 3'b001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
